pong_sprite_controller: RTL and testbench
=========================================

Name: pong_sprite_controller

Overview:
Moore FSM that sequences the 4x4 sprite datapath for one Motion Pong object. The cycle is: load origin, draw 16 pixels, hold for one frame tick, erase 16 pixels, then repeat. It drives the datapath's load, colour-select and counter enables, and consumes the datapath's `done` (pixel 15) and `waited` (frame tick) flags. It also emits the VGA adapter plot strobe, and owns start/stop/pause handling plus a pixel-count watchdog.

Parameters:
- PIXELS, 16, pixels per sprite pass; must equal the datapath pixel-counter period.
- FRAME_W, 8, width of the frame_count output.

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  reset, synchronous, active-low.
- go  in  1  start request; level, sampled only in S_IDLE.
- stop  in  1  stop request; 1-cycle pulse or level, latched.
- pause  in  1  level; freezes the frame wait.
- done  in  1  datapath: pixel counter == PIXELS-1.
- waited  in  1  datapath: frame wait counter == 0.
- ld_x  out  1  datapath x origin load.
- ld_y  out  1  datapath y origin load.
- sel_col  out  1  0 = draw colour, 1 = black (erase).
- enable_posCounter  out  1  advance datapath pixel counter.
- enable_waitCounter  out  1  advance datapath frame wait counter.
- plot  out  1  VGA write enable.
- busy  out  1  high in every state except S_IDLE.
- frame_count  out  FRAME_W  completed draw/erase frames, wraps modulo 2^FRAME_W.
- sync_err  out  1  sticky watchdog error.

Behaviour:
- Control outputs are decoded from the state register only (Moore). frame_count and sync_err are registered.
- Reset (any cycle, including mid-draw): state = S_IDLE, all control outputs = 0, busy = 0, frame_count = 0, sync_err = 0, stop_pend = 0, pix_cnt = 0. The datapath shares resetn, so the pixel counter realigns at 0.
- S_IDLE: all outputs 0. If go=1 and sync_err=0 -> S_LOAD_X. go is ignored in all other states.
- S_LOAD_X: ld_x = 1 for exactly one cycle -> S_LOAD_Y.
- S_LOAD_Y: ld_y = 1 for exactly one cycle -> S_DRAW.
- S_DRAW:
  - Outputs: plot = 1, enable_posCounter = 1, sel_col = 0.
  - pix_cnt (5 bits) increments each cycle.
  - If done = 1: -> S_WAIT and pix_cnt clears. S_DRAW therefore lasts exactly PIXELS cycles and the last plotted pixel is pixel 15.
- S_WAIT:
  - Outputs: plot = 0, sel_col = 0; enable_waitCounter = !pause.
  - If waited = 1: -> S_ERASE, regardless of pause, because the datapath wait counter reloads autonomously.
- S_ERASE:
  - Outputs: plot = 1, enable_posCounter = 1, sel_col = 1.
  - Same pix_cnt and done rules as S_DRAW. On done -> S_UPDATE.
- S_UPDATE: one cycle; frame_count increments.
  - If stop_pend = 1 (or stop = 1 this cycle): -> S_IDLE and stop_pend clears.
  - Otherwise -> S_DRAW. Origin is not reloaded; the datapath x_pos supplies the motion.
- stop handling: stop sets stop_pend in any non-idle state. It is honoured only at S_UPDATE, so the screen is never left with a half-drawn or undrawn sprite. stop in S_IDLE is ignored.
- pause handling: pause affects S_WAIT only. It is ignored in S_DRAW and S_ERASE (a pixel pass is never split) and in the load states.
- Watchdog: in S_DRAW or S_ERASE, if pix_cnt reaches PIXELS with no done seen:
  - sync_err is set (sticky), the next state is S_IDLE, and no further plot is issued.
  - Only resetn clears sync_err. While sync_err = 1, go is blocked.
- Simultaneous done and watchdog expiry on the same cycle: done wins (normal transition).
- Latency: go high in S_IDLE -> first plot 3 cycles later (IDLE, LOAD_X, LOAD_Y, then the first S_DRAW cycle).

Decomposition:
- Shared package pong_pkg:
  - state enum (S_IDLE, S_LOAD_X, S_LOAD_Y, S_DRAW, S_WAIT, S_ERASE, S_UPDATE), 3-bit encoding.
  - constants SPRITE_PIXELS = 16 and FRAME_TICKS = 50_000_000.
- No sub-module; a single FSM plus counters.
- Top level instantiates it beside Datapath with a direct port-name match.

Test Plan:
- Reset, then go = 1 for 1 cycle, with the bench modelling done at cycle 15 of each pass -> ld_x at cycle 1, ld_y at cycle 2, plot = 1 and sel_col = 0 on cycles 3-18 (16 pulses), then busy = 1 and enable_waitCounter = 1.
- In S_WAIT, pulse waited -> next cycle sel_col = 1 and plot = 1 for 16 cycles; then frame_count goes 0 -> 1 and S_DRAW restarts without ld_x/ld_y.
- pause = 1 during S_WAIT for 100 cycles -> enable_waitCounter = 0 throughout. Then waited = 1 while pause is held -> S_ERASE still entered.
- stop pulsed on the 5th S_DRAW cycle -> drawing completes, the wait and erase complete, frame_count increments, then S_IDLE with busy = 0 and no further plot.
- Bench withholds done in S_DRAW -> after 16 plot cycles sync_err = 1, state S_IDLE, and a subsequent go is ignored until resetn = 0.
- resetn = 0 on the 8th S_ERASE cycle -> next cycle all outputs 0, frame_count = 0, sync_err = 0; go then restarts cleanly from S_LOAD_X.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Motion Pong sprite control path.
package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_LOAD_Y = 3'd2,
        S_DRAW   = 3'd3,
        S_WAIT   = 3'd4,
        S_ERASE  = 3'd5,
        S_UPDATE = 3'd6
    } state_t;

    localparam int SPRITE_PIXELS = 16;
    localparam int FRAME_TICKS   = 50_000_000;

endpackage

// File: rtl/pong_sprite_controller.sv
// Moore sequencer for the 4x4 sprite datapath: load origin, draw, hold one frame,
// erase, repeat; with latched stop, wait-only pause and a pixel-count watchdog.
module pong_sprite_controller
    import pong_pkg::*;
#(
    parameter int PIXELS  = SPRITE_PIXELS,
    parameter int FRAME_W = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               go,
    input  logic               stop,
    input  logic               pause,
    input  logic               done,
    input  logic               waited,
    output logic               ld_x,
    output logic               ld_y,
    output logic               sel_col,
    output logic               enable_posCounter,
    output logic               enable_waitCounter,
    output logic               plot,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_count,
    output logic               sync_err
);

    localparam logic [4:0] LAST_PIX = 5'(PIXELS - 1);

    state_t     state;
    logic [4:0] pix_cnt;
    logic       stop_pend;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            pix_cnt     <= '0;
            stop_pend   <= 1'b0;
            frame_count <= '0;
            sync_err    <= 1'b0;
        end else begin
            // Stop is latched here; the case below clears it when it is honoured.
            if (stop && state != S_IDLE)
                stop_pend <= 1'b1;
            case (state)
                S_IDLE:   if (go && !sync_err) state <= S_LOAD_X;
                S_LOAD_X: state <= S_LOAD_Y;
                S_LOAD_Y: state <= S_DRAW;
                S_DRAW, S_ERASE: begin
                    if (done) begin
                        pix_cnt <= '0;
                        state   <= (state == S_DRAW) ? S_WAIT : S_UPDATE;
                    end else if (pix_cnt == LAST_PIX) begin
                        // Datapath lost sync: the next pixel would overrun the sprite.
                        pix_cnt   <= '0;
                        sync_err  <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        pix_cnt <= pix_cnt + 5'd1;
                    end
                end
                S_WAIT:   if (waited) state <= S_ERASE;
                S_UPDATE: begin
                    frame_count <= frame_count + FRAME_W'(1);
                    if (stop_pend || stop) begin
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_DRAW;
                    end
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign ld_x               = (state == S_LOAD_X);
    assign ld_y               = (state == S_LOAD_Y);
    assign sel_col            = (state == S_ERASE);
    assign enable_posCounter  = (state == S_DRAW) || (state == S_ERASE);
    assign plot               = (state == S_DRAW) || (state == S_ERASE);
    assign enable_waitCounter = (state == S_WAIT) && !pause;
    assign busy               = (state != S_IDLE);

endmodule

// File: tb/tb_pong_sprite_controller.sv
// Directed-vector bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the controller outputs.
module tb_pong_sprite_controller;

    logic       clock = 1'b0;
    logic       resetn, go, stop, pause, done, waited;
    logic       ld_x, ld_y, sel_col, enable_posCounter, enable_waitCounter, plot, busy;
    logic [7:0] frame_count;
    logic       sync_err;

    // Control vector order: {ld_x, ld_y, sel_col, enable_posCounter, enable_waitCounter, plot, busy}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_LDX   = 7'b1000001;
    localparam logic [6:0] O_LDY   = 7'b0100001;
    localparam logic [6:0] O_DRAW  = 7'b0001011;
    localparam logic [6:0] O_WAIT  = 7'b0000101;
    localparam logic [6:0] O_WAITP = 7'b0000001;
    localparam logic [6:0] O_ERASE = 7'b0011011;
    localparam logic [6:0] O_UPD   = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] ctl;
        logic [7:0] fc;
        logic       err;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc_n      = 0;
    int   compared   = 0;
    int   mismatched = 0;

    pong_sprite_controller #(.PIXELS(16), .FRAME_W(8)) dut (
        .clock              (clock),
        .resetn             (resetn),
        .go                 (go),
        .stop               (stop),
        .pause              (pause),
        .done               (done),
        .waited             (waited),
        .ld_x               (ld_x),
        .ld_y               (ld_y),
        .sel_col            (sel_col),
        .enable_posCounter  (enable_posCounter),
        .enable_waitCounter (enable_waitCounter),
        .plot               (plot),
        .busy               (busy),
        .frame_count        (frame_count),
        .sync_err           (sync_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc_n) begin
            logic [6:0] act;
            mon_e = q.pop_front();
            act = {ld_x, ld_y, sel_col, enable_posCounter, enable_waitCounter, plot, busy};
            compared++;
            if (mon_e.cyc != cyc_n || act !== mon_e.ctl || frame_count !== mon_e.fc
                || sync_err !== mon_e.err) begin
                mismatched++;
                $display("[TB] FAIL %s @cycle %0d: got ctl=%b fc=%0d err=%b, want ctl=%b fc=%0d err=%b",
                         mon_e.tag, cyc_n, act, frame_count, sync_err, mon_e.ctl, mon_e.fc, mon_e.err);
            end
        end
    end

    task automatic step(input logic rst, input logic g, input logic s, input logic p,
                        input logic d, input logic w, input logic chk,
                        input logic [6:0] ctl, input logic [7:0] fc, input logic err,
                        input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        resetn = rst; go = g; stop = s; pause = p; done = d; waited = w;
        if (chk) begin
            e.cyc = cyc_n; e.ctl = ctl; e.fc = fc; e.err = err; e.tag = tag;
            q.push_back(e);
        end
    endtask

    // One 16-pixel pass; done is modelled on the 16th cycle when with_done is set.
    task automatic pixel_pass(input logic erase, input logic [7:0] fc, input int stop_idx,
                              input logic with_done, input logic p, input string tag);
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, i == stop_idx, p, with_done && i == 15, 1'b0, 1'b1,
                 erase ? O_ERASE : O_DRAW, fc, 1'b0, tag);
    endtask

    task automatic wait_phase(input int n, input logic p, input logic [7:0] fc, input string tag);
        for (int i = 0; i <= n; i++)
            step(1'b1, 1'b0, 1'b0, p, 1'b0, i == n, 1'b1, p ? O_WAITP : O_WAIT, fc, 1'b0, tag);
    endtask

    initial begin
        resetn = 1'b0; go = 1'b0; stop = 1'b0; pause = 1'b0; done = 1'b0; waited = 1'b0;

        step(1'b0, 0, 0, 0, 0, 0, 1'b0, O_IDLE, 8'd0, 1'b0, "");
        step(1'b0, 0, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b0, "reset");
        step(1'b1, 0, 1, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b0, "stop_in_idle");
        step(1'b1, 1, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b0, "idle_go");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDX,  8'd0, 1'b0, "ld_x");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDY,  8'd0, 1'b0, "ld_y");
        pixel_pass(1'b0, 8'd0, -1, 1'b1, 1'b0, "draw1");
        wait_phase(3, 1'b0, 8'd0, "wait1");
        pixel_pass(1'b1, 8'd0, -1, 1'b1, 1'b0, "erase1");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_UPD, 8'd0, 1'b0, "update1");

        pixel_pass(1'b0, 8'd1, -1, 1'b1, 1'b0, "redraw_no_load");
        wait_phase(100, 1'b1, 8'd1, "wait_paused");
        pixel_pass(1'b1, 8'd1, -1, 1'b1, 1'b1, "erase_after_pause");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_UPD, 8'd1, 1'b0, "update2");

        pixel_pass(1'b0, 8'd2, 4, 1'b1, 1'b0, "draw_stop");
        wait_phase(2, 1'b0, 8'd2, "wait_stop");
        pixel_pass(1'b1, 8'd2, -1, 1'b1, 1'b0, "erase_stop");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_UPD, 8'd2, 1'b0, "update_stop");
        for (int i = 0; i < 3; i++)
            step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd3, 1'b0, "stopped_idle");

        step(1'b1, 1, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd3, 1'b0, "go_again");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDX,  8'd3, 1'b0, "ld_x_again");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDY,  8'd3, 1'b0, "ld_y_again");
        pixel_pass(1'b0, 8'd3, -1, 1'b1, 1'b0, "draw4");
        wait_phase(1, 1'b0, 8'd3, "wait4");
        for (int i = 0; i < 8; i++)
            step(i == 7 ? 1'b0 : 1'b1, 0, 0, 0, 0, 0, 1'b1, O_ERASE, 8'd3, 1'b0, "erase_pre_reset");
        step(1'b1, 1, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b0, "reset_mid_erase");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDX,  8'd0, 1'b0, "ld_x_after_reset");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDY,  8'd0, 1'b0, "ld_y_after_reset");

        pixel_pass(1'b0, 8'd0, -1, 1'b0, 1'b0, "draw_no_done");
        step(1'b1, 1, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b1, "watchdog_trip");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b1, "go_blocked");
        step(1'b1, 1, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b1, "go_blocked");
        step(1'b0, 0, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b1, "err_sticky");
        step(1'b1, 1, 0, 0, 0, 0, 1'b1, O_IDLE, 8'd0, 1'b0, "reset_clears_err");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDX,  8'd0, 1'b0, "restart_ld_x");
        step(1'b1, 0, 0, 0, 0, 0, 1'b1, O_LDY,  8'd0, 1'b0, "restart_ld_y");

        repeat (3) @(posedge clock);
        if (q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
